// File: rtl/result_display_driver_pkg.sv
// Shared definitions for the calculator result display: converter FSM states,
// 7-segment digit codes and the double-dabble nibble adjust.
package result_display_driver_pkg;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  localparam int unsigned BIN_W = 8;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned CNT_W = 4;

  // cnt value during the eighth (final) shift
  localparam logic [CNT_W-1:0] LAST_SHIFT = 4'd7;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [2:0] AN_OFF  = 3'b111;
  localparam logic [2:0] AN_UNIT = 3'b110;
  localparam logic [2:0] AN_TENS = 3'b101;
  localparam logic [2:0] AN_HUND = 3'b011;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin8_to_bcd_serial.sv
// Serial 8-bit binary to 3-digit BCD (double dabble): start accepted in IDLE,
// 8 SHIFT clocks, one DONE clock with done_o high; busy_o covers SHIFT and DONE.
module bin8_to_bcd_serial
  import result_display_driver_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  conv_state_t            state_q;
  logic [BIN_W-1:0]       bin_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   busy_q;
  logic                   done_q;
  logic [BCD_W+BIN_W-1:0] shift_d;

  assign shift_d = {dabble_adjust(bcd_q), bin_q} << 1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        CONV_IDLE: begin
          if (start_i) begin
            bcd_q   <= '0;
            bin_q   <= value_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          {bcd_q, bin_q} <= shift_d;
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == LAST_SHIFT) begin
            done_q  <= 1'b1;
            state_q <= CONV_DONE;
          end
        end
        CONV_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= CONV_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= CONV_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_display_driver.sv
// Shows the held 8-bit result as decimal on a 3-digit multiplexed active-low display.
// Result -> digits in 10 clocks; digits are scanned every SCAN_DIV clocks per slot.
module result_display_driver
  import result_display_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [BIN_W-1:0] Result,
  output logic [6:0]       Seg,
  output logic [2:0]       An,
  output logic             Busy
);

  localparam int unsigned     PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [BIN_W-1:0] sample_q;
  logic [BIN_W-1:0] last_q;
  logic [BIN_W-1:0] conv_val_q;
  logic [BCD_W-1:0] disp_q;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [6:0]       seg_q;
  logic [6:0]       seg_d;
  logic [2:0]       an_q;
  logic [2:0]       an_d;
  logic [3:0]       digit;
  logic             blank;
  logic             start;
  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  // A new conversion only starts once the previous one has fully retired.
  assign start = (sample_q != last_q) && !conv_busy;

  bin8_to_bcd_serial u_bcd (
    .clk_i   (clock),
    .rst_i   (reset),
    .start_i (start),
    .value_i (sample_q),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    digit = disp_q[3:0];
    blank = 1'b0;
    an_d  = AN_UNIT;
    case (idx_d)
      2'd1: begin
        digit = disp_q[7:4];
        blank = BLANK_LEADING && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
        an_d  = AN_TENS;
      end
      2'd2: begin
        digit = disp_q[11:8];
        blank = BLANK_LEADING && (disp_q[11:8] == 4'd0);
        an_d  = AN_HUND;
      end
      default: begin
        digit = disp_q[3:0];
        blank = 1'b0;
        an_d  = AN_UNIT;
      end
    endcase
    seg_d = blank ? SEG_BLANK : seg_decode(digit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_q   <= '0;
      last_q     <= '0;
      conv_val_q <= '0;
      disp_q     <= '0;
      pre_q      <= '0;
      idx_q      <= 2'd0;
      seg_q      <= SEG_BLANK;
      an_q       <= AN_OFF;
    end else begin
      sample_q <= Result;
      if (start) begin
        conv_val_q <= sample_q;
      end
      if (conv_done) begin
        disp_q <= conv_bcd;
        last_q <= conv_val_q;
      end
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign Seg  = seg_q;
  assign An   = an_q;
  assign Busy = conv_busy;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench: three display instances (blanking, no blanking, SCAN_DIV=1) on one stimulus.
module tb_result_display_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] Result = 8'd0;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [2:0] an_a, an_b, an_c;
  logic       busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  result_display_driver #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
    .clock(clock), .reset(reset), .Result(Result), .Seg(seg_a), .An(an_a), .Busy(busy_a)
  );
  result_display_driver #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
    .clock(clock), .reset(reset), .Result(Result), .Seg(seg_b), .An(an_b), .Busy(busy_b)
  );
  result_display_driver #(.SCAN_DIV(1), .BLANK_LEADING(1'b1)) dut_c (
    .clock(clock), .reset(reset), .Result(Result), .Seg(seg_c), .An(an_c), .Busy(busy_c)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for the given digit enable; returns 8'hEE on timeout.
  task automatic read_slot(input int which, input logic [2:0] pat, output logic [7:0] seg);
    logic found;
    found = 1'b0;
    seg   = 8'hEE;
    for (int n = 0; n < 16 && !found; n++) begin
      tick();
      if (which == 0 && an_a == pat) begin seg = {1'b0, seg_a}; found = 1'b1; end
      if (which == 1 && an_b == pat) begin seg = {1'b0, seg_b}; found = 1'b1; end
      if (which == 2 && an_c == pat) begin seg = {1'b0, seg_c}; found = 1'b1; end
    end
  endtask

  task automatic slot_chk(input string tag, input int which, input logic [2:0] pat,
                          input logic [6:0] exp);
    logic [7:0] s;
    read_slot(which, pat, s);
    chk(tag, 32'(s), 32'(exp));
  endtask

  initial begin
    int nb;
    int cnt;
    logic [7:0] s;
    logic [2:0] cur;
    logic [2:0] seq [3];
    seq = '{3'b101, 3'b011, 3'b110};

    // 1: reset state and zero display
    repeat (3) tick();
    chk("rst_seg", 32'(seg_a), 32'h7F);
    chk("rst_an", 32'(an_a), 32'(3'b111));
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_an_b", 32'(an_b), 32'(3'b111));
    reset = 1'b0;
    tick();
    chk("first_an", 32'(an_a), 32'(3'b110));
    chk("first_seg", 32'(seg_a), 32'h40);
    slot_chk("zero_t", 0, 3'b101, 7'h7F);
    slot_chk("zero_h", 0, 3'b011, 7'h7F);
    slot_chk("zero_u", 0, 3'b110, 7'h40);
    slot_chk("zero_h_nb", 1, 3'b011, 7'h40);

    // 2: 0 -> 255, busy length and disp timing
    Result = 8'd255;
    tick();
    chk("busy_k", 32'(busy_a), 0);
    nb = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (busy_a) nb++;
      if (i == 1) chk("busy_k1", 32'(busy_a), 1);
      if (i == 9) chk("disp_k9", 32'(dut_a.disp_q), 32'h000);
      if (i == 10) begin
        chk("busy_k10", 32'(busy_a), 0);
        chk("disp_k10", 32'(dut_a.disp_q), 32'h255);
      end
    end
    chk("busy_len", nb, 9);
    slot_chk("f255_u", 0, 3'b110, 7'h12);
    slot_chk("f255_t", 0, 3'b101, 7'h12);
    slot_chk("f255_h", 0, 3'b011, 7'h24);

    // 3: 7, blanked and unblanked
    Result = 8'd7;
    repeat (12) tick();
    chk("disp_7", 32'(dut_a.disp_q), 32'h007);
    slot_chk("s7_h", 0, 3'b011, 7'h7F);
    slot_chk("s7_t", 0, 3'b101, 7'h7F);
    slot_chk("s7_u", 0, 3'b110, 7'h78);
    slot_chk("s7_h_nb", 1, 3'b011, 7'h40);
    slot_chk("s7_t_nb", 1, 3'b101, 7'h40);
    slot_chk("s7_u_nb", 1, 3'b110, 7'h78);

    // 4: 100, changed to 42 mid-conversion
    Result = 8'd100;
    tick();
    tick();
    chk("busy_100", 32'(busy_a), 1);
    tick();
    Result = 8'd42;
    repeat (7) tick();
    chk("disp_k9_100", 32'(dut_a.disp_q), 32'h007);
    tick();
    chk("disp_100", 32'(dut_a.disp_q), 32'h100);
    chk("busy_gap", 32'(busy_a), 0);
    tick();
    chk("busy_restart", 32'(busy_a), 1);
    repeat (9) tick();
    chk("disp_42", 32'(dut_a.disp_q), 32'h042);
    slot_chk("s42_h", 0, 3'b011, 7'h7F);
    slot_chk("s42_t", 0, 3'b101, 7'h19);
    slot_chk("s42_u", 0, 3'b110, 7'h24);

    // 5: reset during SHIFT
    Result = 8'd88;
    repeat (4) tick();
    chk("busy_pre_rst", 32'(busy_a), 1);
    reset = 1'b1;
    #2;
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_seg", 32'(seg_a), 32'h7F);
    chk("arst_an", 32'(an_a), 32'(3'b111));
    chk("arst_disp", 32'(dut_a.disp_q), 32'h000);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rel_an", 32'(an_a), 32'(3'b110));
    chk("rel_seg", 32'(seg_a), 32'h40);
    repeat (11) tick();
    chk("disp_88", 32'(dut_a.disp_q), 32'h088);
    slot_chk("s88_u", 0, 3'b110, 7'h00);
    slot_chk("s88_t", 0, 3'b101, 7'h00);
    slot_chk("s88_h", 0, 3'b011, 7'h7F);

    // 6: scan order and hold time
    read_slot(0, 3'b011, s);
    read_slot(0, 3'b110, s);
    chk("scan_align", 32'(s == 8'hEE), 0);
    cur = 3'b110;
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (an_a == cur && cnt < 20);
      chk("scan_hold", cnt, 4);
      chk("scan_next", 32'(an_a), 32'(seq[k]));
      cur = an_a;
    end
    read_slot(2, 3'b110, s);
    chk("div1_align", 32'(s == 8'hEE), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("div1_next", 32'(an_c), 32'(seq[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
